bch_codeword_assembler: RTL and testbench

- Serial-to-parallel front end for the BCH(63,51) decoder.
- Collects demodulated hard-decision bits one at a time into 63-bit codewords.
- Holds each complete codeword in an output register with a valid/ready handshake, and the decoder's in_data port is driven directly from it.
- Supports re-alignment from a start-of-codeword marker and flags codewords lost to back-pressure.

---
 rtl/bch_codeword_assembler.sv | 71 +++++++
 tb/tb_bch_codeword_assembler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_codeword_assembler.sv
// Serial-to-parallel front end for the BCH(63,51) decoder: collects hard-decision
// bits MSB-first into N-bit codewords and presents them through a valid/ready register.
module bch_codeword_assembler #(
    parameter int N     = 63,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf_pulse,
    output logic [CNT_W-1:0] blk_cnt,
    output logic [5:0]       bit_idx
);

    // Only N-1 bits need storing; the final bit is taken straight from in_bit.
    logic [N-2:0] shift_reg;
    logic [N-1:0] word;
    logic         last_bit;
    logic         complete;
    logic         accept;
    logic         out_free;

    always_comb begin
        word     = {shift_reg, in_bit};
        last_bit = (bit_idx == 6'(N - 1));
        complete = in_valid & ~in_sof & last_bit;
        accept   = out_valid & out_ready;
        out_free = ~out_valid | out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_idx   <= '0;
        end else if (in_valid) begin
            if (in_sof) begin
                shift_reg <= (N - 1)'(in_bit);
                bit_idx   <= 6'd1;
            end else begin
                shift_reg <= {shift_reg[N-3:0], in_bit};
                bit_idx   <= last_bit ? 6'd0 : bit_idx + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            ovf_pulse <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            ovf_pulse <= complete & ~out_free;
            if (complete && out_free) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                blk_cnt <= blk_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bch_codeword_assembler.sv
// Directed self-checking bench for bch_codeword_assembler; a narrow counter
// width is used so that the counter wrap is reachable in a short run.
module tb_bch_codeword_assembler;

    localparam int N     = 63;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_bit = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_data;
    logic             out_valid;
    logic             ovf_pulse;
    logic [CNT_W-1:0] blk_cnt;
    logic [5:0]       bit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    bch_codeword_assembler #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf_pulse (ovf_pulse),
        .blk_cnt   (blk_cnt),
        .bit_idx   (bit_idx)
    );

    always #5 clk = ~clk;

    task automatic send_bit(input logic b, input logic s);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        in_sof   = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [N-1:0] exp_word;
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || ovf_pulse !== 1'b0 ||
            blk_cnt !== '0 || bit_idx !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b data=%h ovf=%b cnt=%0d idx=%0d, required all 0",
                     out_valid, out_data, ovf_pulse, blk_cnt, bit_idx);
        end
        out_ready = 1'b1;
        exp_word  = '0;
        exp_word[N-1] = 1'b1;
        for (int i = 0; i < N; i++) send_bit(i == 0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_word) begin
            n_fail++;
            $display("FAIL single_word: valid=%b data=%h, required valid=1 data=%h",
                     out_valid, out_data, exp_word);
        end
        idle_cycle();
        n_checks++;
        if (out_valid !== 1'b0 || blk_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL single_accept: valid=%b cnt=%0d, required valid=0 cnt=1", out_valid, blk_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] pats [3];
        logic [N-1:0] w;
        int nv;
        int novf;
        pats[0] = 63'h7FFF_FFFF_FFFF_FFFF;
        pats[1] = 63'h5555_5555_5555_5555;
        pats[2] = 63'h0;
        nv   = 0;
        novf = 0;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = pats[k];
            for (int i = N - 1; i >= 0; i--) begin
                send_bit(w[i], 1'b0);
                if (out_valid) nv++;
                if (ovf_pulse) novf++;
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== w) begin
                n_fail++;
                $display("FAIL b2b_word%0d: valid=%b data=%h, required valid=1 data=%h",
                         k, out_valid, out_data, w);
            end
        end
        idle_cycle();
        n_checks++;
        if (nv != 3 || novf != 0) begin
            n_fail++;
            $display("FAIL b2b_pulses: valid_cycles=%0d ovf_cycles=%0d, required 3 and 0", nv, novf);
        end
        n_checks++;
        if (out_valid !== 1'b0 || blk_cnt !== 3'd3 || bit_idx !== 6'd0) begin
            n_fail++;
            $display("FAIL b2b_end: valid=%b cnt=%0d idx=%0d, required 0 3 0", out_valid, blk_cnt, bit_idx);
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0] a;
        logic [N-1:0] b;
        int novf;
        int unstable;
        a = 63'h0123_4567_89AB_CDEF;
        b = 63'h7EDC_BA98_7654_3210;
        novf = 0;
        unstable = 0;
        do_reset();
        out_ready = 1'b0;
        for (int i = N - 1; i >= 0; i--) send_bit(a[i], 1'b0);
        for (int i = N - 1; i >= 0; i--) begin
            send_bit(b[i], 1'b0);
            if (out_valid !== 1'b1 || out_data !== a) unstable++;
            if (ovf_pulse) novf++;
        end
        n_checks++;
        if (ovf_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_timing: ovf=%b after dropped word, required 1", ovf_pulse);
        end
        for (int i = 0; i < 4; i++) begin
            idle_cycle();
            if (out_valid !== 1'b1 || out_data !== a) unstable++;
            if (ovf_pulse) novf++;
        end
        n_checks++;
        if (novf != 1 || unstable != 0) begin
            n_fail++;
            $display("FAIL ovf_hold: ovf_cycles=%0d unstable=%0d, required 1 and 0", novf, unstable);
        end
        out_ready = 1'b1;
        idle_cycle();
        n_checks++;
        if (out_valid !== 1'b0 || blk_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL ovf_release: valid=%b cnt=%0d, required valid=0 cnt=1", out_valid, blk_cnt);
        end
    endtask

    task automatic test_accept_and_complete();
        logic [N-1:0] a;
        logic [N-1:0] b;
        a = 63'h2AAA_0000_FFFF_1234;
        b = 63'h1555_FFFF_0000_4321;
        do_reset();
        out_ready = 1'b0;
        for (int i = N - 1; i >= 0; i--) send_bit(a[i], 1'b0);
        for (int i = N - 1; i >= 1; i--) send_bit(b[i], 1'b0);
        out_ready = 1'b1;
        send_bit(b[0], 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== b || ovf_pulse !== 1'b0 || blk_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL accept_complete: valid=%b data=%h ovf=%b cnt=%0d, required 1 %h 0 1",
                     out_valid, out_data, ovf_pulse, blk_cnt, b);
        end
        idle_cycle();
        n_checks++;
        if (out_valid !== 1'b0 || blk_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL accept_second: valid=%b cnt=%0d, required valid=0 cnt=2", out_valid, blk_cnt);
        end
    endtask

    task automatic test_sof();
        logic [N-1:0] exp_word;
        int early;
        early = 0;
        exp_word = '0;
        exp_word[N-1] = 1'b1;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
        n_checks++;
        if (bit_idx !== 6'd20) begin
            n_fail++;
            $display("FAIL sof_pre_idx: idx=%0d, required 20", bit_idx);
        end
        send_bit(1'b1, 1'b1);
        n_checks++;
        if (bit_idx !== 6'd1) begin
            n_fail++;
            $display("FAIL sof_idx: idx=%0d, required 1", bit_idx);
        end
        for (int i = 0; i < N - 2; i++) begin
            send_bit(1'b0, 1'b0);
            if (out_valid) early++;
        end
        send_bit(1'b0, 1'b0);
        n_checks++;
        if (early != 0 || out_valid !== 1'b1 || out_data !== exp_word) begin
            n_fail++;
            $display("FAIL sof_word: early=%0d valid=%b data=%h, required 0 1 %h",
                     early, out_valid, out_data, exp_word);
        end
        idle_cycle();
        for (int i = 0; i < N - 1; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        n_checks++;
        if (bit_idx !== 6'd1 || out_valid !== 1'b0 || ovf_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL sof_at_last: idx=%0d valid=%b ovf=%b, required 1 0 0", bit_idx, out_valid, ovf_pulse);
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] a;
        logic [N-1:0] c;
        a = 63'h3C3C_3C3C_3C3C_3C3C;
        c = 63'h1234_5678_9ABC_DEF0;
        do_reset();
        out_ready = 1'b0;
        for (int i = N - 1; i >= 0; i--) send_bit(a[i], 1'b0);
        for (int i = 0; i < 40; i++) send_bit(1'b1, 1'b0);
        n_checks++;
        if (bit_idx !== 6'd40 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: idx=%0d valid=%b, required 40 1", bit_idx, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || bit_idx !== 6'd0 || blk_cnt !== '0 || ovf_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b data=%h idx=%0d cnt=%0d ovf=%b, required all 0",
                     out_valid, out_data, bit_idx, blk_cnt, ovf_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = N - 1; i >= 0; i--) send_bit(c[i], 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== c) begin
            n_fail++;
            $display("FAIL post_reset_word: valid=%b data=%h, required 1 %h", out_valid, out_data, c);
        end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < N; i++) send_bit(1'b1, 1'b0);
        end
        idle_cycle();
        n_checks++;
        if (blk_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL cnt_wrap: cnt=%0d after 9 words, required 1", blk_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_accept_and_complete();
        test_sof();
        test_async_reset();
        test_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
